req_ack_xfr_responder: RTL

- Target-side responder for the req/ack/xfr burst protocol; sits directly downstream of the requester and drives the ack/xfr pair that the protocol assertions check.
- Buffers source data in a small FIFO and acks a request only when a full burst of REP beats is already buffered. This makes xfr gap-free for the whole burst.
- Signals a timeout if it cannot ack within MAX_WAIT cycles of the request edge.

---
 rtl/req_ack_xfr_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/req_ack_xfr_responder.sv
// Target-side req/ack/xfr responder: buffers source words and acks only once a full burst is held.
// Ack at least 2 cycles after the req rise. src_ready drops while the FIFO is full or in reset.
module req_ack_xfr_responder #(
    parameter int DW       = 8,
    parameter int REP      = 2,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    input  logic          req,
    output logic          ack,
    output logic          xfr,
    output logic [DW-1:0] xfr_data,
    output logic          timeout,
    output logic          busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(REP + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, XFER} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          req_q;
    logic          timeout_q, timeout_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic req_rise;
    logic push;
    logic pop;

    assign req_rise  = req & ~req_q;
    assign src_ready = (count_q < CW'(DEPTH)) & ~rst;
    assign push      = src_valid & src_ready;
    assign pop       = (state_q == XFER);

    assign ack      = (state_q == ACK);
    assign xfr      = (state_q == XFER);
    assign xfr_data = xfr ? mem_q[rd_ptr_q] : '0;
    assign timeout  = timeout_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Readiness wins over timeout when both hold in the same WAIT cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_cnt_d = beat_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_rise) begin
                    state_d    = WAIT;
                    wait_cnt_d = WW'(1);
                end
            end
            WAIT: begin
                if (count_q >= CW'(REP)) begin
                    state_d = ACK;
                end else if (wait_cnt_q == WW'(MAX_WAIT)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            ACK: begin
                beat_cnt_d = '0;
                state_d    = XFER;
            end
            XFER: begin
                beat_cnt_d = beat_cnt_q + BW'(1);
                if (beat_cnt_d == BW'(REP)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            req_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            req_q      <= req;
            timeout_q  <= timeout_d;
        end
    end

    // Storage needs no reset: reads are masked unless a burst is in flight.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= src_data;
        end
    end

endmodule
